// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter; the grant is held for the owner's whole CYC.
// Define WB_ARB_TIMEOUT_EN to add a stall watchdog that errors and drains the owner.
module wb_rr_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]     m_ADR,
    input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_DAT_W,
    input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0] m_SEL,
    input  logic [N_MASTERS*3-1:0]                 m_CTI,
    input  logic [N_MASTERS*2-1:0]                 m_BTE,
    input  logic [N_MASTERS-1:0]                   m_CYC,
    input  logic [N_MASTERS-1:0]                   m_STB,
    input  logic [N_MASTERS-1:0]                   m_WE,
    output logic [WB_DATA_WIDTH-1:0]               m_DAT_R,
    output logic [N_MASTERS-1:0]                   m_ACK,
    output logic [N_MASTERS-1:0]                   m_ERR,
    output logic [WB_ADDR_WIDTH-1:0]               s_ADR,
    output logic [WB_DATA_WIDTH-1:0]               s_DAT_W,
    output logic [WB_DATA_WIDTH/8-1:0]             s_SEL,
    output logic [2:0]                             s_CTI,
    output logic [1:0]                             s_BTE,
    output logic                                   s_CYC,
    output logic                                   s_STB,
    output logic                                   s_WE,
    input  logic [WB_DATA_WIDTH-1:0]               s_DAT_R,
    input  logic                                   s_ACK,
    input  logic                                   s_ERR,
    output logic [N_MASTERS-1:0]                   gnt
);

    localparam int IW = $clog2(N_MASTERS);
    localparam int SW = WB_DATA_WIDTH / 8;

    if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_bad_n
        $error("N_MASTERS must be within 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE,
`ifdef WB_ARB_TIMEOUT_EN
        BUSY,
        DRAIN
`else
        BUSY
`endif
    } state_e;

    state_e              state_q;
    logic [N_MASTERS-1:0] gnt_q;
    logic [IW-1:0]       own_q;
    logic [IW-1:0]       last_q;
    logic [IW-1:0]       win_d;
    logic [IW-1:0]       cand;
    logic                hit;
    logic                busy;

    logic [WB_ADDR_WIDTH-1:0] adr_a [N_MASTERS];
    logic [WB_DATA_WIDTH-1:0] dat_a [N_MASTERS];
    logic [SW-1:0]            sel_a [N_MASTERS];
    logic [2:0]               cti_a [N_MASTERS];
    logic [1:0]               bte_a [N_MASTERS];

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
        assign adr_a[i] = m_ADR[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
        assign dat_a[i] = m_DAT_W[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
        assign sel_a[i] = m_SEL[i*SW +: SW];
        assign cti_a[i] = m_CTI[i*3 +: 3];
        assign bte_a[i] = m_BTE[i*2 +: 2];
    end

    // First requester above the last owner, wrapping around.
    always_comb begin
        win_d = last_q;
        cand  = '0;
        hit   = 1'b0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand = IW'((int'(last_q) + k) % N_MASTERS);
            if (!hit && m_CYC[cand]) begin
                win_d = cand;
                hit   = 1'b1;
            end
        end
    end

    assign busy = (state_q == BUSY);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] tmo_q;
    logic          stall;
    logic          tmo_hit;

    assign stall   = busy && m_CYC[own_q] && m_STB[own_q] && !s_ACK && !s_ERR;
    assign tmo_hit = stall && (tmo_q == CW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        s_ADR   = '0;
        s_DAT_W = '0;
        s_SEL   = '0;
        s_CTI   = '0;
        s_BTE   = '0;
        s_CYC   = 1'b0;
        s_STB   = 1'b0;
        s_WE    = 1'b0;
        m_ACK   = '0;
        m_ERR   = '0;
        if (busy) begin
            s_ADR   = adr_a[own_q];
            s_DAT_W = dat_a[own_q];
            s_SEL   = sel_a[own_q];
            s_CTI   = cti_a[own_q];
            s_BTE   = bte_a[own_q];
            s_CYC   = m_CYC[own_q];
            s_STB   = m_STB[own_q];
            s_WE    = m_WE[own_q];
            // A reset in flight abandons the transfer without a response.
            if (!rst) begin
                m_ACK[own_q] = s_ACK;
                m_ERR[own_q] = s_ERR;
            end
        end
`ifdef WB_ARB_TIMEOUT_EN
        if (tmo_hit && !rst) begin
            m_ERR[own_q] = 1'b1;
        end
`endif
    end

    assign m_DAT_R = s_DAT_R;
    assign gnt     = gnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            own_q   <= '0;
            last_q  <= IW'(N_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|m_CYC) begin
                        state_q <= BUSY;
                        own_q   <= win_d;
                        gnt_q   <= N_MASTERS'(1) << win_d;
                    end
                end
                BUSY: begin
                    if (!m_CYC[own_q]) begin
                        state_q <= IDLE;
                        last_q  <= own_q;
                        gnt_q   <= '0;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_q <= DRAIN;
                    end
`endif
                end
`ifdef WB_ARB_TIMEOUT_EN
                DRAIN: begin
                    if (!m_CYC[own_q]) begin
                        state_q <= IDLE;
                        last_q  <= own_q;
                        gnt_q   <= '0;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
`ifdef WB_ARB_TIMEOUT_EN
            tmo_q <= (stall && !tmo_hit) ? tmo_q + CW'(1) : '0;
`endif
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a round-robin reference model through a scoreboard.
module tb_wb_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*AW-1:0] m_ADR   = '0;
    logic [N*DW-1:0] m_DAT_W = '0;
    logic [N*SW-1:0] m_SEL   = '0;
    logic [N*3-1:0]  m_CTI   = '0;
    logic [N*2-1:0]  m_BTE   = '0;
    logic [N-1:0]    m_CYC   = '0;
    logic [N-1:0]    m_STB   = '0;
    logic [N-1:0]    m_WE    = '0;
    logic [DW-1:0]   m_DAT_R;
    logic [N-1:0]    m_ACK, m_ERR;
    logic [AW-1:0]   s_ADR;
    logic [DW-1:0]   s_DAT_W;
    logic [SW-1:0]   s_SEL;
    logic [2:0]      s_CTI;
    logic [1:0]      s_BTE;
    logic            s_CYC, s_STB, s_WE;
    logic [DW-1:0]   s_DAT_R = '0;
    logic            s_ACK = 1'b0;
    logic            s_ERR = 1'b0;
    logic [N-1:0]    gnt;

    wb_rr_arbiter #(
        .N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(256)
    ) dut (
        .clk(clk), .rst(rst),
        .m_ADR(m_ADR), .m_DAT_W(m_DAT_W), .m_SEL(m_SEL), .m_CTI(m_CTI),
        .m_BTE(m_BTE), .m_CYC(m_CYC), .m_STB(m_STB), .m_WE(m_WE),
        .m_DAT_R(m_DAT_R), .m_ACK(m_ACK), .m_ERR(m_ERR),
        .s_ADR(s_ADR), .s_DAT_W(s_DAT_W), .s_SEL(s_SEL), .s_CTI(s_CTI),
        .s_BTE(s_BTE), .s_CYC(s_CYC), .s_STB(s_STB), .s_WE(s_WE),
        .s_DAT_R(s_DAT_R), .s_ACK(s_ACK), .s_ERR(s_ERR), .gnt(gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  gnt;
        logic          cyc, stb, we;
        logic [AW-1:0] adr;
        logic [DW-1:0] datw;
        logic [SW-1:0] sel;
        logic [2:0]    cti;
        logic [1:0]    bte;
        logic [N-1:0]  ack, err;
        logic [DW-1:0] datr;
    } exp_t;

    typedef struct {
        int            m;
        int            nb;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic          we;
    } txn_t;

    exp_t exp_q[$];
    txn_t pend[$];
    int   glog[$];

    int total = 0;
    int bad = 0;
    int cyc_no = 0;
    int own_m = -1;
    int last_m = N - 1;
    int ack_pct = 100;
    int err_pct = 0;
    logic rst_req = 1'b1;

    bit            act[N];
    int            left[N];
    int            start_cyc[N];
    int            ackcnt[N];
    logic [AW-1:0] cur_adr[N];
    logic [N-1:0]  ack_seen = '0;
    logic [N-1:0]  prev_gnt = '0;
    logic          prev_scyc = 1'b0;
    int            sc_rise = 0;
    logic [AW-1:0] sc_adr = '0;
    logic [DW-1:0] sc_dat = '0;

    function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, a, e);
        end
    endfunction

    // Reference arbiter: owner index (-1 = bus free) and last owner.
    task automatic model_step();
        if (rst) begin
            own_m  = -1;
            last_m = N - 1;
        end else if (own_m < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last_m + k) % N;
                if (own_m < 0 && m_CYC[c]) own_m = c;
            end
        end else if (!m_CYC[own_m]) begin
            last_m = own_m;
            own_m  = -1;
        end
    endtask

    task automatic set_master(int i, logic cyc, logic [AW-1:0] a,
                              logic [DW-1:0] d, logic we, logic [2:0] cti);
        m_CYC[i] = cyc;
        m_STB[i] = cyc;
        m_WE[i]  = we;
        m_ADR[i*AW +: AW]   = a;
        m_DAT_W[i*DW +: DW] = d;
        m_SEL[i*SW +: SW]   = cyc ? 4'($urandom_range(1, 15)) : 4'h0;
        m_CTI[i*3 +: 3]     = cti;
        m_BTE[i*2 +: 2]     = 2'b00;
    endtask

    task automatic drive_masters();
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                act[i] = 1'b0;
                set_master(i, 1'b0, '0, '0, 1'b0, 3'b000);
            end else if (act[i]) begin
                if (ack_seen[i]) begin
                    left[i]--;
                    if (left[i] == 0) begin
                        act[i] = 1'b0;
                        set_master(i, 1'b0, '0, '0, 1'b0, 3'b000);
                    end else begin
                        cur_adr[i] = cur_adr[i] + 4;
                        set_master(i, 1'b1, cur_adr[i], $urandom, m_WE[i],
                                   left[i] == 1 ? 3'b111 : 3'b010);
                    end
                end
            end else begin
                for (int j = 0; j < pend.size(); j++) begin
                    if (!act[i] && pend[j].m == i) begin
                        act[i]       = 1'b1;
                        left[i]      = pend[j].nb;
                        cur_adr[i]   = pend[j].adr;
                        start_cyc[i] = cyc_no;
                        set_master(i, 1'b1, pend[j].adr, pend[j].dat, pend[j].we,
                                   pend[j].nb == 1 ? 3'b000 : 3'b010);
                        pend.delete(j);
                    end
                end
            end
        end
    endtask

    task automatic drive_slave();
        s_DAT_R = $urandom;
        s_ACK   = 1'b0;
        s_ERR   = 1'b0;
        if (s_CYC && s_STB && $urandom_range(99) < ack_pct) begin
            if ($urandom_range(99) < err_pct) s_ERR = 1'b1;
            else s_ACK = 1'b1;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.gnt = '0; e.cyc = 1'b0; e.stb = 1'b0; e.we = 1'b0;
        e.adr = '0; e.datw = '0; e.sel = '0; e.cti = '0; e.bte = '0;
        e.ack = '0; e.err = '0;
        e.datr = s_DAT_R;
        if (own_m >= 0) begin
            e.gnt[own_m] = 1'b1;
            e.cyc  = m_CYC[own_m];
            e.stb  = m_STB[own_m];
            e.we   = m_WE[own_m];
            e.adr  = m_ADR[own_m*AW +: AW];
            e.datw = m_DAT_W[own_m*DW +: DW];
            e.sel  = m_SEL[own_m*SW +: SW];
            e.cti  = m_CTI[own_m*3 +: 3];
            e.bte  = m_BTE[own_m*2 +: 2];
            if (!rst) begin
                e.ack[own_m] = s_ACK;
                e.err[own_m] = s_ERR;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        cyc_no++;
        #1;
        rst = rst_req;
        drive_masters();
        #1;
        drive_slave();
        #1;
        push_expected();
    endtask

    task automatic run_until_idle(int maxc);
        bit done;
        done = 1'b0;
        for (int k = 0; k < maxc && !done; k++) begin
            cycle();
            if (pend.size() == 0 && act[0] == 0 && act[1] == 0 && act[2] == 0
                && own_m < 0 && gnt == '0) done = 1'b1;
        end
        chk("settle", 64'(done), 64'd1);
    endtask

    // Monitor: compares every DUT-visible output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt",   64'(gnt),     64'(e.gnt));
                chk("s_cyc", 64'(s_CYC),   64'(e.cyc));
                chk("s_stb", 64'(s_STB),   64'(e.stb));
                chk("s_we",  64'(s_WE),    64'(e.we));
                chk("s_adr", 64'(s_ADR),   64'(e.adr));
                chk("s_datw",64'(s_DAT_W), 64'(e.datw));
                chk("s_sel", 64'(s_SEL),   64'(e.sel));
                chk("s_cti", 64'(s_CTI),   64'(e.cti));
                chk("s_bte", 64'(s_BTE),   64'(e.bte));
                chk("m_ack", 64'(m_ACK),   64'(e.ack));
                chk("m_err", 64'(m_ERR),   64'(e.err));
                chk("m_datr",64'(m_DAT_R), 64'(e.datr));
                ack_seen = m_ACK | m_ERR;
                for (int k = 0; k < N; k++) if (m_ACK[k]) ackcnt[k]++;
                if (gnt != '0 && prev_gnt == '0) begin
                    for (int k = 0; k < N; k++) if (gnt[k]) glog.push_back(k);
                end
                if (s_CYC && !prev_scyc) begin
                    sc_rise = cyc_no;
                    sc_adr  = s_ADR;
                    sc_dat  = s_DAT_W;
                end
                prev_gnt  = gnt;
                prev_scyc = s_CYC;
            end
        end
    end

    initial begin
        int a0, a1;
        txn_t t;

        rst_req = 1'b1;
        repeat (3) cycle();
        rst_req = 1'b0;
        cycle();

        // Lone master 1 single write.
        pend.push_back('{1, 1, 32'h100, 32'hDEADBEEF, 1'b1});
        run_until_idle(20);
        chk("t1_order", 64'(glog.size() == 1 ? glog[0] : -1), 64'd1);
        chk("t1_lat",   64'(sc_rise - start_cyc[1]), 64'd1);
        chk("t1_adr",   64'(sc_adr), 64'h100);
        chk("t1_dat",   64'(sc_dat), 64'hDEADBEEF);
        chk("t1_ack1",  64'(ackcnt[1]), 64'd1);
        chk("t1_ack0",  64'(ackcnt[0]), 64'd0);

        // Masters 0 and 1 together.
        glog.delete();
        pend.push_back('{0, 1, 32'h10, 32'h1111, 1'b1});
        pend.push_back('{1, 1, 32'h20, 32'h2222, 1'b1});
        run_until_idle(30);
        chk("t2_n",  64'(glog.size()), 64'd2);
        chk("t2_g0", 64'(glog.size() > 0 ? glog[0] : -1), 64'd0);
        chk("t2_g1", 64'(glog.size() > 1 ? glog[1] : -1), 64'd1);

        // Three masters, nine single reads.
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        cycle();
        glog.delete();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++)
                pend.push_back('{i, 1, 32'(32'h400 + 16 * i + 4 * r), 32'h0, 1'b0});
        run_until_idle(120);
        chk("t3_n", 64'(glog.size()), 64'd9);
        for (int k = 0; k < 9; k++)
            chk("t3_seq", 64'(glog.size() > k ? glog[k] : -1), 64'(k % 3));

        // Four-beat burst on master 0 while master 1 waits.
        glog.delete();
        a0 = ackcnt[0];
        a1 = ackcnt[1];
        ack_pct = 60;
        pend.push_back('{0, 4, 32'h200, 32'hA0A0, 1'b1});
        pend.push_back('{1, 1, 32'h300, 32'hB0B0, 1'b1});
        run_until_idle(150);
        chk("t4_n",    64'(glog.size()), 64'd2);
        chk("t4_g0",   64'(glog.size() > 0 ? glog[0] : -1), 64'd0);
        chk("t4_g1",   64'(glog.size() > 1 ? glog[1] : -1), 64'd1);
        chk("t4_ack0", 64'(ackcnt[0] - a0), 64'd4);
        chk("t4_ack1", 64'(ackcnt[1] - a1), 64'd1);

        // Reset while master 0 owns the bus.
        ack_pct = 0;
        a0 = ackcnt[0];
        pend.push_back('{0, 4, 32'h500, 32'hC0C0, 1'b0});
        for (int k = 0; k < 10 && gnt !== 3'b001; k++) cycle();
        chk("t5_own", 64'(gnt), 64'd1);
        cycle();
        glog.delete();
        rst_req = 1'b1;
        pend.push_back('{2, 1, 32'h600, 32'hD0D0, 1'b1});
        cycle();
        rst_req = 1'b0;
        cycle();
        chk("t5_scyc", 64'(s_CYC), 64'd0);
        chk("t5_gnt0", 64'(gnt), 64'd0);
        ack_pct = 100;
        run_until_idle(30);
        chk("t5_g2",   64'(glog.size() == 1 ? glog[0] : -1), 64'd2);
        chk("t5_ack0", 64'(ackcnt[0] - a0), 64'd0);

        // Random traffic with occasional errors and resets.
        err_pct = 5;
        for (int n = 0; n < 3000; n++) begin
            if (n % 50 == 0) ack_pct = $urandom_range(30, 100);
            if ($urandom_range(99) < 15 && pend.size() < 6) begin
                t.m   = $urandom_range(N - 1);
                t.nb  = $urandom_range(1, 4);
                t.adr = {$urandom} & 32'hFFFF_FFFC;
                t.dat = $urandom;
                t.we  = 1'($urandom_range(1));
                pend.push_back(t);
            end
            rst_req = ($urandom_range(499) == 0);
            cycle();
        end
        rst_req = 1'b0;
        run_until_idle(400);
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
